mouse_packet_decoder: RTL

- Assembles the 3-byte PS/2 mouse stream into one decoded movement/button record per packet.
- Input is the byte strobe from PS2_Controller (received_data / received_data_en).
- Output is signed deltas, buttons and a one-cycle packet_ready pulse that drives the cursor-position and drawing state machine.
- Adds byte-0 sync checking, inter-byte timeout resynchronisation, ACK filtering, overflow handling and error counters.

---
 rtl/mouse_packet_decoder_pkg.sv | 25 ++
 rtl/mouse_packet_decoder_if.sv | 34 +++
 rtl/mouse_packet_decoder_ps2_gap_timer.sv | 29 ++
 rtl/mouse_packet_decoder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mouse_packet_decoder_pkg.sv
// mouse_pkg: shared types and constants for the PS/2 mouse packet decoder.
//   state_t   - packet assembly states
//   BTN_*/SYNC/XS/YS/XO/YO - bit positions inside the byte-0 header
//   PS2_ACK   - acknowledge byte the mouse sends after host commands
package mouse_pkg;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2,
    EMIT    = 2'd3
  } state_t;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XS    = 4;
  localparam int YS    = 5;
  localparam int XO    = 6;
  localparam int YO    = 7;

  localparam logic [7:0] PS2_ACK = 8'hFA;

endpackage

// File: rtl/mouse_packet_decoder_if.sv
// mouse_packet_decoder_if: byte stream in, decoded packet record out.
//   ps2_byte/ps2_byte_en      - received byte and its one-cycle strobe
//   delta_x/delta_y           - 9-bit two's complement movement
//   buttons                   - {middle, right, left}
//   packet_ready              - one-cycle pulse, record updated this cycle
//   x_ovf/y_ovf               - overflow flags of the last packet
//   sync_err_cnt/timeout_cnt  - saturating error counters
// master drives the byte stream, slave is the decoder.
interface mouse_packet_decoder_if #(
  parameter int ERR_CNT_W = 8
);
  logic [7:0]           ps2_byte;
  logic                 ps2_byte_en;
  logic [8:0]           delta_x;
  logic [8:0]           delta_y;
  logic [2:0]           buttons;
  logic                 packet_ready;
  logic                 x_ovf;
  logic                 y_ovf;
  logic [ERR_CNT_W-1:0] sync_err_cnt;
  logic [ERR_CNT_W-1:0] timeout_cnt;

  modport master (
    output ps2_byte, ps2_byte_en,
    input  delta_x, delta_y, buttons, packet_ready, x_ovf, y_ovf,
           sync_err_cnt, timeout_cnt
  );

  modport slave (
    input  ps2_byte, ps2_byte_en,
    output delta_x, delta_y, buttons, packet_ready, x_ovf, y_ovf,
           sync_err_cnt, timeout_cnt
  );
endinterface

// File: rtl/mouse_packet_decoder_ps2_gap_timer.sv
// ps2_gap_timer: counts idle cycles between bytes of one packet.
//   clk, rst - clock, async active-high reset
//   clear    - restart from 0 (byte accepted)
//   enable   - count this cycle; held at 0 while disabled
//   expired  - count has reached TIMEOUT_CYCLES while enabled
module ps2_gap_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] cnt;

  // Sticks at LIMIT so expired stays asserted until the FSM reacts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (clear || !enable)  cnt <= '0;
    else if (cnt != LIMIT)      cnt <= cnt + 1'b1;
  end

  assign expired = enable && (cnt == LIMIT);

endmodule

// File: rtl/mouse_packet_decoder.sv
// mouse_packet_decoder: assembles 3-byte PS/2 mouse packets into one
// movement/button record and pulses packet_ready for one cycle.
//   clk, rst - 50 MHz clock, async active-high reset
//   bus      - slave side of mouse_packet_decoder_if (byte stream in,
//              decoded record and error counters out)
// Byte 0 is validated by its always-one sync bit; ACK bytes (0xFA) seen
// while hunting for byte 0 are optionally dropped; a partial packet is
// abandoned after TIMEOUT_CYCLES idle cycles.
module mouse_packet_decoder
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FILTER_ACK     = 1,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mouse_packet_decoder_if.slave bus
);

  state_t state_q, state_d;

  logic [7:0] b0_reg, b1_reg, b2_reg;
  logic [8:0] dx_q;
  logic       ys_q, xo_q, yo_q;
  logic [2:0] btn_q;
  logic [ERR_CNT_W-1:0] sync_q, tmo_q;

  logic ld_b0, ld_b1, ld_b2, sync_inc, tmo_inc;
  logic expired, timer_en;

  // Only meaningful while a packet is partially received.
  assign timer_en = (state_q == WAIT_B1) || (state_q == WAIT_B2);

  ps2_gap_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (ld_b1 || ld_b2),
    .enable  (timer_en),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= WAIT_B0;
    else     state_q <= state_d;
  end

  // EMIT behaves as WAIT_B0 for an incoming byte so back-to-back
  // packets lose nothing. A byte in the timeout cycle takes priority.
  always_comb begin
    state_d  = state_q;
    ld_b0    = 1'b0;
    ld_b1    = 1'b0;
    ld_b2    = 1'b0;
    sync_inc = 1'b0;
    tmo_inc  = 1'b0;
    case (state_q)
      WAIT_B0, EMIT: begin
        state_d = WAIT_B0;
        if (bus.ps2_byte_en) begin
          if ((FILTER_ACK != 0) && (bus.ps2_byte == PS2_ACK)) begin
            state_d = WAIT_B0;
          end else if (!bus.ps2_byte[SYNC]) begin
            sync_inc = 1'b1;
          end else begin
            ld_b0   = 1'b1;
            state_d = WAIT_B1;
          end
        end
      end
      WAIT_B1: begin
        if (bus.ps2_byte_en) begin
          ld_b1   = 1'b1;
          state_d = WAIT_B2;
        end else if (expired) begin
          tmo_inc = 1'b1;
          state_d = WAIT_B0;
        end
      end
      WAIT_B2: begin
        if (bus.ps2_byte_en) begin
          ld_b2   = 1'b1;
          state_d = EMIT;
        end else if (expired) begin
          tmo_inc = 1'b1;
          state_d = WAIT_B0;
        end
      end
      default: state_d = WAIT_B0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b0_reg <= '0;
      b1_reg <= '0;
    end else begin
      if (ld_b0) b0_reg <= bus.ps2_byte;
      if (ld_b1) b1_reg <= bus.ps2_byte;
    end
  end

  // The record registers load on the edge that enters EMIT, so the new
  // values and packet_ready appear together in the EMIT cycle. b2_reg
  // doubles as the Y magnitude, which is why it loads only here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b2_reg <= '0;
      dx_q   <= '0;
      ys_q   <= 1'b0;
      xo_q   <= 1'b0;
      yo_q   <= 1'b0;
      btn_q  <= '0;
    end else if (ld_b2) begin
      b2_reg <= bus.ps2_byte;
      dx_q   <= b0_reg[XO] ? 9'd0 : {b0_reg[XS], b1_reg};
      ys_q   <= b0_reg[YS];
      xo_q   <= b0_reg[XO];
      yo_q   <= b0_reg[YO];
      btn_q  <= {b0_reg[BTN_M], b0_reg[BTN_R], b0_reg[BTN_L]};
    end
  end

  // Sync bit is always set once latched; it carries no record data.
  logic unused_sync;
  assign unused_sync = b0_reg[SYNC];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      tmo_q  <= '0;
    end else begin
      if (sync_inc && (sync_q != '1)) sync_q <= sync_q + 1'b1;
      if (tmo_inc  && (tmo_q  != '1)) tmo_q  <= tmo_q + 1'b1;
    end
  end

  assign bus.delta_x      = dx_q;
  assign bus.delta_y      = yo_q ? 9'd0 : {ys_q, b2_reg};
  assign bus.buttons      = btn_q;
  assign bus.x_ovf        = xo_q;
  assign bus.y_ovf        = yo_q;
  assign bus.packet_ready = (state_q == EMIT);
  assign bus.sync_err_cnt = sync_q;
  assign bus.timeout_cnt  = tmo_q;

endmodule
